wc_winograd_f43: RTL and testbench

- Fully pipelined 1-D Winograd F(4,3) engine with a fixed, hard-wired transformed kernel.
- Each cycle it accepts one 6-element signed input tile and produces 4 signed output values.
- Sits in the convolution datapath between the tile fetch logic and the accumulation stage.

---
 rtl/wc_winograd_f43.sv | 74 +++++++
 tb/tb_wc_winograd_f43.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wc_winograd_f43.sv
// 1-D Winograd F(4,3) engine with a hard-wired transformed kernel.
// Four-stage pipeline: capture, input transform, elementwise product, output transform.
module wc_winograd_f43 #(
  parameter int DW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6*DW-1:0] D,
  output logic [4*DW-1:0] Z
);

  localparam int IW = 24;

  logic [6*DW-1:0]        d_r;
  logic signed [IW-1:0]   d   [6];
  logic signed [IW-1:0]   m_n [6];
  logic signed [IW-1:0]   m_r [6];
  logic signed [IW-1:0]   p_n [6];
  logic signed [IW-1:0]   p_r [6];
  logic        [DW-1:0]   y_n [4];

  // d0 lives in the most significant field of the tile
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      d[i] = {{(IW-DW){d_r[(5-i)*DW+DW-1]}}, d_r[(5-i)*DW +: DW]};
    end
  end

  always_comb begin
    m_n[0] = (d[0] <<< 2) - (d[2] <<< 2) - d[2] + d[4];
    m_n[1] = -(d[1] <<< 2) - (d[2] <<< 2) + d[3] + d[4];
    m_n[2] = (d[1] <<< 2) - (d[2] <<< 2) - d[3] + d[4];
    m_n[3] = -(d[1] <<< 1) - d[2] + (d[3] <<< 1) + d[4];
    m_n[4] = (d[1] <<< 1) - d[2] - (d[3] <<< 1) + d[4];
    m_n[5] = (d[1] <<< 2) - (d[3] <<< 2) - d[3] + d[5];
  end

  // Kernel U = [1, -3, -3, 2, 2, 13] folded into shift-and-add constants
  always_comb begin
    p_n[0] = m_r[0];
    p_n[1] = -((m_r[1] <<< 1) + m_r[1]);
    p_n[2] = -((m_r[2] <<< 1) + m_r[2]);
    p_n[3] = m_r[3] <<< 1;
    p_n[4] = m_r[4] <<< 1;
    p_n[5] = (m_r[5] <<< 3) + (m_r[5] <<< 2) + m_r[5];
  end

  // Results wrap to DW bits; no saturation
  always_comb begin
    y_n[0] = DW'(p_r[0] + p_r[1] + p_r[2] + p_r[3] + p_r[4]);
    y_n[1] = DW'(p_r[1] - p_r[2] + (p_r[3] <<< 1) - (p_r[4] <<< 1));
    y_n[2] = DW'(p_r[1] + p_r[2] + (p_r[3] <<< 2) + (p_r[4] <<< 2));
    y_n[3] = DW'(p_r[1] - p_r[2] + (p_r[3] <<< 3) - (p_r[4] <<< 3) + p_r[5]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_r <= '0;
      for (int i = 0; i < 6; i++) begin
        m_r[i] <= '0;
        p_r[i] <= '0;
      end
      Z <= '0;
    end else begin
      d_r <= D;
      for (int i = 0; i < 6; i++) begin
        m_r[i] <= m_n[i];
        p_r[i] <= p_n[i];
      end
      Z <= {y_n[0], y_n[1], y_n[2], y_n[3]};
    end
  end

endmodule

// File: tb/tb_wc_winograd_f43.sv
// Bench for wc_winograd_f43: vector table, streaming/reset sequences and a
// matrix-form reference model feeding an output scoreboard.
module tb_wc_winograd_f43;

  logic        clk;
  logic        rst;
  logic [59:0] D;
  logic [39:0] Z;

  int applied;
  int miscompares;

  logic [39:0] sbq[$];

  typedef struct {
    string       name;
    logic [59:0] d;
    logic [39:0] z;
  } vec_t;

  vec_t tbl[6];

  int bt [6][6] = '{'{4, 0, -5,  0, 1, 0},
                    '{0, -4, -4, 1, 1, 0},
                    '{0, 4, -4, -1, 1, 0},
                    '{0, -2, -1, 2, 1, 0},
                    '{0, 2, -1, -2, 1, 0},
                    '{0, 4, 0, -5, 0, 1}};
  int at [4][6] = '{'{1, 1, 1, 1, 1, 0},
                    '{0, 1, -1, 2, -2, 0},
                    '{0, 1, 1, 4, 4, 0},
                    '{0, 1, -1, 8, -8, 1}};
  int u  [6]    = '{1, -3, -3, 2, 2, 13};

  wc_winograd_f43 #(.DW(10)) dut (
    .clk(clk),
    .rst(rst),
    .D  (D),
    .Z  (Z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [39:0] model(input logic [59:0] dv);
    int          dd [6];
    int          m  [6];
    int          y;
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) dd[i] = int'($signed(dv[(5-i)*10 +: 10]));
    for (int i = 0; i < 6; i++) begin
      m[i] = 0;
      for (int j = 0; j < 6; j++) m[i] += bt[i][j] * dd[j];
      m[i] *= u[i];
    end
    for (int k = 0; k < 4; k++) begin
      y = 0;
      for (int i = 0; i < 6; i++) y += at[k][i] * m[i];
      r[(3-k)*10 +: 10] = y[9:0];
    end
    return r;
  endfunction

  function automatic logic [59:0] rnd60();
    return 60'({$urandom, $urandom});
  endfunction

  task automatic checkOutput(input string name, input logic [39:0] act, input logic [39:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the scoreboard holds the three results still in flight
  task automatic applyStimulus(input logic [59:0] dv, input logic r);
    logic [39:0] exp;
    @(negedge clk);
    D   = dv;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      sbq.delete();
      repeat (3) sbq.push_back(40'd0);
      checkOutput("reset", Z, 40'd0);
    end else begin
      sbq.push_back(model(dv));
      if (sbq.size() > 3) begin
        exp = sbq.pop_front();
        checkOutput("scoreboard", Z, exp);
      end
    end
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    D   = '0;
    rst = 1'b1;

    tbl[0] = '{"vec2", 60'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110,
               40'b0001000010_1111011000_1110010110_1010000010};
    tbl[1] = '{"vec3", {10'h3ED, 10'h3FA, 10'd3, 10'h3F7, 10'h3F4, 10'd11},
               40'b1111101101_1101110110_1110100000_0010000110};
    tbl[2] = '{"imp_d0", {10'd1, 50'd0}, {10'd4, 30'd0}};
    tbl[3] = '{"imp_d4", {40'd0, 10'd1, 10'd0}, {10'h3FF, 10'd0, 10'd10, 10'd0}};
    tbl[4] = '{"imp_d5", 60'd1, 40'd13};
    tbl[5] = '{"wrap_d5", 60'd40, {30'd0, 10'd520}};

    applyStimulus(60'hfedcba987654321, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(rnd60(), 1'b1);

    for (int i = 0; i < 6; i++) begin
      repeat (4) applyStimulus(tbl[i].d, 1'b0);
      checkOutput(tbl[i].name, Z, tbl[i].z);
    end

    // Back-to-back tiles come out on consecutive edges
    applyStimulus(tbl[1].d, 1'b0);
    applyStimulus(tbl[0].d, 1'b0);
    applyStimulus(tbl[2].d, 1'b0);
    applyStimulus(tbl[3].d, 1'b0);
    checkOutput("stream_vec3", Z, tbl[1].z);
    applyStimulus(tbl[4].d, 1'b0);
    checkOutput("stream_vec2", Z, tbl[0].z);
    applyStimulus(tbl[5].d, 1'b0);
    checkOutput("stream_imp_d0", Z, tbl[2].z);
    applyStimulus(60'd0, 1'b0);
    checkOutput("stream_imp_d4", Z, tbl[3].z);
    applyStimulus(60'd0, 1'b0);
    checkOutput("stream_imp_d5", Z, tbl[4].z);
    applyStimulus(60'd0, 1'b0);
    checkOutput("stream_wrap", Z, tbl[5].z);

    // Reset on the second edge of a held tile discards it
    applyStimulus(tbl[0].d, 1'b0);
    applyStimulus(tbl[0].d, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(tbl[0].d, 1'b0);
      checkOutput("midreset_zero", Z, 40'd0);
    end
    applyStimulus(tbl[0].d, 1'b0);
    checkOutput("midreset_vec2", Z, tbl[0].z);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(rnd60(), ($urandom_range(0, 39) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
